// File: rtl/usb_pkg.sv
// Shared constants, SETUP field offsets, FSM states and the parsed SETUP record
// for the EP0 SET_ADDRESS handler.
package usb_pkg;

  localparam logic [7:0] USB_REQ_SET_ADDRESS = 8'h05;
  localparam logic [7:0] BMREQ_STD_DEV_OUT   = 8'h00;

  // Byte positions of the standard request fields within the 8-byte SETUP data.
  localparam logic [2:0] OFS_BM_REQ_TYPE = 3'd0;
  localparam logic [2:0] OFS_B_REQUEST   = 3'd1;
  localparam logic [2:0] OFS_W_VALUE_LO  = 3'd2;
  localparam logic [2:0] OFS_W_VALUE_HI  = 3'd3;
  localparam logic [2:0] OFS_W_INDEX_LO  = 3'd4;
  localparam logic [2:0] OFS_W_INDEX_HI  = 3'd5;
  localparam logic [2:0] OFS_W_LENGTH_LO = 3'd6;
  localparam logic [2:0] OFS_W_LENGTH_HI = 3'd7;

  localparam logic [3:0] SETUP_LEN = 4'd8;
  localparam logic [3:0] CNT_OVF   = 4'd9;  // saturation value: more than 8 bytes seen

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_SETUP,
    ST_WAIT_STATUS,
    ST_COMMIT
  } sa_state_e;

  typedef struct packed {
    logic [7:0]  bm_req_type;
    logic [7:0]  b_request;
    logic [15:0] w_value;
    logic [15:0] w_index;
    logic [15:0] w_length;
  } setup_pkt_t;

endpackage

// File: rtl/usb_set_address_ctrl_if.sv
// Decoder-side events in, EP0 transmitter / address-register controls out.
interface usb_set_address_ctrl_if;
  logic       usb_reset;
  logic       setup_start;
  logic       setup_byte_vld;
  logic [7:0] setup_byte;
  logic       setup_end;
  logic       setup_crc_ok;
  logic       in_token_ep0;
  logic       out_token_ep0;
  logic       host_ack;

  logic       zlp_arm;
  logic       setaddr_claim;
  logic       stall_req;
  logic       addr_wr_en;
  logic [6:0] addr_wr_addr;

  // Packet decoder / bench side.
  modport master (
    output usb_reset, setup_start, setup_byte_vld, setup_byte, setup_end,
           setup_crc_ok, in_token_ep0, out_token_ep0, host_ack,
    input  zlp_arm, setaddr_claim, stall_req, addr_wr_en, addr_wr_addr
  );

  // SET_ADDRESS handler side.
  modport slave (
    input  usb_reset, setup_start, setup_byte_vld, setup_byte, setup_end,
           setup_crc_ok, in_token_ep0, out_token_ep0, host_ack,
    output zlp_arm, setaddr_claim, stall_req, addr_wr_en, addr_wr_addr
  );
endinterface

// File: rtl/usb_setup_capture.sv
// Counts SETUP data bytes (saturating at 9 = overflow) and latches the eight
// request bytes into the standard request fields.
module usb_setup_capture
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       byte_vld,
  input  logic [7:0] byte_in,
  output setup_pkt_t pkt,
  output logic       len_ok
);

  logic [3:0] byte_cnt;
  logic [7:0] field_mem [8];

  // Byte counter: restarts on each SETUP token, sticks at the overflow value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (byte_vld && (byte_cnt != CNT_OVF)) begin
      byte_cnt <= byte_cnt + 4'd1;
    end
  end

  // Field latch: byte N of the packet lands in slot N.
  // NOTE: the field storage has no reset; it is only consumed when len_ok shows all eight slots were just rewritten.
  always_ff @(posedge clk) begin
    if (!clear && byte_vld && (byte_cnt < SETUP_LEN)) begin
      field_mem[byte_cnt[2:0]] <= byte_in;
    end
  end

  assign pkt.bm_req_type = field_mem[OFS_BM_REQ_TYPE];
  assign pkt.b_request   = field_mem[OFS_B_REQUEST];
  assign pkt.w_value     = {field_mem[OFS_W_VALUE_HI],  field_mem[OFS_W_VALUE_LO]};
  assign pkt.w_index     = {field_mem[OFS_W_INDEX_HI],  field_mem[OFS_W_INDEX_LO]};
  assign pkt.w_length    = {field_mem[OFS_W_LENGTH_HI], field_mem[OFS_W_LENGTH_LO]};
  assign len_ok          = (byte_cnt == SETUP_LEN);

endmodule

// File: rtl/usb_set_address_ctrl.sv
// EP0 SET_ADDRESS handler: decodes the request, arms the zero-length status IN,
// and writes the new address only after the host ACKs that status packet.
// A USB bus reset forces a write of address 0.
module usb_set_address_ctrl
  import usb_pkg::*;
#(
  parameter bit          STRICT_CHECK   = 1'b1,
  parameter logic [15:0] STATUS_TIMEOUT = 16'd50000
) (
  input logic                   clk,
  input logic                   rst_n,
  usb_set_address_ctrl_if.slave bus
);

  sa_state_e   state, state_nxt;
  logic        in_seen, in_seen_nxt;
  logic [15:0] timer, timer_nxt;
  logic [6:0]  new_addr, new_addr_nxt;
  logic        stall_q, stall_nxt;
  logic        wr_en_q, wr_en_nxt;
  logic [6:0]  wr_addr_q, wr_addr_nxt;

  setup_pkt_t  pkt;
  logic        len_ok;
  logic        is_set_addr;
  logic        req_valid;

  usb_setup_capture u_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.setup_start),
    .byte_vld (bus.setup_byte_vld && (state == ST_RX_SETUP)),
    .byte_in  (bus.setup_byte),
    .pkt      (pkt),
    .len_ok   (len_ok)
  );

  assign is_set_addr = (pkt.bm_req_type == BMREQ_STD_DEV_OUT) &&
                       (pkt.b_request == USB_REQ_SET_ADDRESS);
  assign req_valid   = (pkt.w_value[15:7] == '0) &&
                       (!STRICT_CHECK || ((pkt.w_index == '0) && (pkt.w_length == '0)));

  // State, status-stage bookkeeping and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_seen   <= 1'b0;
      timer     <= '0;
      new_addr  <= '0;
      stall_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state     <= state_nxt;
      in_seen   <= in_seen_nxt;
      timer     <= timer_nxt;
      new_addr  <= new_addr_nxt;
      stall_q   <= stall_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
    end
  end

  // Next state: bus reset, then a new SETUP, then per-state events.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches), and blocking '=' is used so timer_nxt is usable below.
  always_comb begin
    state_nxt    = state;
    in_seen_nxt  = in_seen;
    timer_nxt    = timer;
    new_addr_nxt = new_addr;
    stall_nxt    = 1'b0;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr_q;

    if (bus.usb_reset) begin
      state_nxt   = ST_IDLE;
      in_seen_nxt = 1'b0;
      timer_nxt   = '0;
      wr_en_nxt   = 1'b1;
      wr_addr_nxt = '0;
    end else if (bus.setup_start) begin
      state_nxt   = ST_RX_SETUP;
      in_seen_nxt = 1'b0;
      timer_nxt   = '0;
    end else begin
      unique case (state)
        ST_RX_SETUP: begin
          if (bus.setup_end) begin
            state_nxt = ST_IDLE;
            if (bus.setup_crc_ok && len_ok && is_set_addr) begin
              if (req_valid) begin
                new_addr_nxt = pkt.w_value[6:0];
                state_nxt    = ST_WAIT_STATUS;
              end else begin
                stall_nxt = 1'b1;
              end
            end
          end
        end
        ST_WAIT_STATUS: begin
          timer_nxt = timer + 16'd1;
          if (bus.in_token_ep0) begin
            in_seen_nxt = 1'b1;
          end
          if (bus.out_token_ep0) begin
            stall_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else if (bus.host_ack && in_seen) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = new_addr;
            state_nxt   = ST_COMMIT;
          end else if ((STATUS_TIMEOUT != 16'd0) && (timer_nxt == STATUS_TIMEOUT)) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_COMMIT: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          in_seen_nxt = 1'b0;
          timer_nxt   = '0;
        end
      endcase
    end
  end

  assign bus.zlp_arm       = (state == ST_WAIT_STATUS);
  assign bus.setaddr_claim = (state == ST_WAIT_STATUS);
  assign bus.stall_req     = stall_q;
  assign bus.addr_wr_en    = wr_en_q;
  assign bus.addr_wr_addr  = wr_addr_q;

endmodule
